z80_io_port: RTL and testbench

Z80 I/O-space peripheral on the `mclk` domain, directly downstream of the Z80 core's bus pins. It synchronises the core's active-low strobes, decodes I/O write and read cycles on the low address byte, and drives two ports: a write-only LED output register and a read-only switch input port. Interrupt-acknowledge cycles and cycles to unmapped ports are tracked and ignored. The Z80 runs on a divided clock, so all bus inputs are asynchronous to `mclk`.

---
 rtl/z80_io_pkg.sv | 17 +
 rtl/z80_bus_sync.sv | 31 +++
 rtl/z80_io_port.sv | 111 +++++++++++
 tb/tb_z80_io_port.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_io_pkg.sv
// z80_io_pkg: shared types and constants for the Z80 I/O-space peripheral.
//   io_state_e    - bus-cycle tracking FSM states
//   LED_PORT_DEF  - default I/O address of the LED output register
//   SW_PORT_DEF   - default I/O address of the switch input port
package z80_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HOLD = 2'd1,
    RD_HOLD = 2'd2,
    IGNORE  = 2'd3
  } io_state_e;

  localparam logic [7:0] LED_PORT_DEF = 8'h01;
  localparam logic [7:0] SW_PORT_DEF  = 8'h02;

endpackage

// File: rtl/z80_bus_sync.sv
// z80_bus_sync: WIDTH-bit, STAGES-deep flop chain that brings asynchronous
// Z80 bus / board signals into the mclk domain.
//   mclk  - system clock
//   reset - asynchronous active-high reset; every stage loads RESET_VAL
//   d     - asynchronous input bits
//   q     - synchronised output (last stage)
module z80_bus_sync #(
  parameter int                 WIDTH     = 4,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/z80_io_port.sv
// z80_io_port: Z80 I/O-space peripheral with a write-only LED register and a
// read-only switch port, decoded on the low address byte.
//   mclk, reset        - system clock, asynchronous active-high reset
//   nIORQ/nRD/nWR/nM1  - Z80 strobes, active low, asynchronous
//   A, D_in            - address byte and CPU write data (stable while strobed)
//   D_out, D_oe        - read data and bus-drive enable for the switch port
//   sw                 - board switches, asynchronous
//   Led, wr_strobe     - LED register and one-cycle accepted-write pulse
//
// state   | meaning
// IDLE    | no bus cycle in progress, waiting for synced nIORQ low
// WR_HOLD | LED write done, waiting for the write strobe to end
// RD_HOLD | switch data latched and driven, waiting for the read to end
// IGNORE  | unmapped port or interrupt acknowledge, waiting for nIORQ high
module z80_io_port
  import z80_io_pkg::*;
#(
  parameter logic [7:0] LED_PORT    = LED_PORT_DEF,
  parameter logic [7:0] SW_PORT     = SW_PORT_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic       nM1,
  input  logic [7:0] A,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] sw,
  output logic [7:0] Led,
  output logic       wr_strobe
);

  logic [3:0] strobe_s;
  logic [7:0] sw_s;
  logic       iorq_s, rd_s, wr_s, m1_s;
  io_state_e  state;

  z80_bus_sync #(
    .WIDTH     (4),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (4'hF)
  ) u_strobe_sync (
    .mclk  (mclk),
    .reset (reset),
    .d     ({nM1, nWR, nRD, nIORQ}),
    .q     (strobe_s)
  );

  z80_bus_sync #(
    .WIDTH     (8),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (8'h00)
  ) u_sw_sync (
    .mclk  (mclk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  assign {m1_s, wr_s, rd_s, iorq_s} = strobe_s;

  // A and D_in are used raw: the CPU holds them stable across the whole
  // strobe-low window, which outlasts the synchroniser delay.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      Led       <= 8'h00;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!iorq_s) begin
            // write wins if both strobes are seen low together
            if (!wr_s && m1_s && (A == LED_PORT)) begin
              Led       <= D_in;
              wr_strobe <= 1'b1;
              state     <= WR_HOLD;
            end else if (!rd_s && m1_s && (A == SW_PORT)) begin
              D_out <= sw_s;
              D_oe  <= 1'b1;
              state <= RD_HOLD;
            end else begin
              state <= IGNORE;
            end
          end
        end
        WR_HOLD: begin
          if (iorq_s || wr_s) state <= IDLE;
        end
        RD_HOLD: begin
          if (iorq_s || rd_s) begin
            D_oe  <= 1'b0;
            state <= IDLE;
          end
        end
        IGNORE: begin
          if (iorq_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_port.sv
module tb_z80_io_port;
  import z80_io_pkg::*;

  localparam int S = 2;

  logic       mclk = 1'b0;
  logic       reset;
  logic       nIORQ, nRD, nWR, nM1;
  logic [7:0] A, D_in, sw;
  logic [7:0] D_out, Led;
  logic       D_oe, wr_strobe;

  int n_vec = 0;
  int n_err = 0;
  int stb_count = 0;
  logic prev_stb = 1'b0;
  logic run = 1'b0;

  always #5 mclk = ~mclk;

  z80_io_port #(
    .LED_PORT    (8'h01),
    .SW_PORT     (8'h02),
    .SYNC_STAGES (S)
  ) dut (
    .mclk      (mclk),
    .reset     (reset),
    .nIORQ     (nIORQ),
    .nRD       (nRD),
    .nWR       (nWR),
    .nM1       (nM1),
    .A         (A),
    .D_in      (D_in),
    .D_out     (D_out),
    .D_oe      (D_oe),
    .sw        (sw),
    .Led       (Led),
    .wr_strobe (wr_strobe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the block reacts to the bus as it looked S edges
  // earlier; a bus cycle is classified once when nIORQ is first seen low
  // and lasts until its own strobe is seen released.
  typedef struct packed {
    logic       iorq, rd, wr, m1;
    logic [7:0] sw;
  } bus_t;

  bus_t       hist[$];
  bus_t       view;
  string      m_cycle;
  logic [7:0] m_led, m_dout;
  logic       m_oe, m_stb;

  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back({1'b1, 1'b1, 1'b1, 1'b1, 8'h00});
      m_cycle = "none";
      m_led = 8'h00; m_dout = 8'h00; m_oe = 1'b0; m_stb = 1'b0;
    end else begin
      view = hist.pop_front();
      hist.push_back({nIORQ, nRD, nWR, nM1, sw});
      m_stb = 1'b0;
      if (m_cycle == "none") begin
        if (!view.iorq) begin
          if (!view.wr && view.m1 && A == 8'h01) begin
            m_led = D_in; m_stb = 1'b1; m_cycle = "write";
          end else if (!view.rd && view.m1 && A == 8'h02) begin
            m_dout = view.sw; m_oe = 1'b1; m_cycle = "read";
          end else begin
            m_cycle = "other";
          end
        end
      end else if (m_cycle == "write") begin
        if (view.iorq || view.wr) m_cycle = "none";
      end else if (m_cycle == "read") begin
        if (view.iorq || view.rd) begin m_oe = 1'b0; m_cycle = "none"; end
      end else begin
        if (view.iorq) m_cycle = "none";
      end
    end
  end

  always @(negedge mclk) begin
    if (run && !reset) begin
      check("model_led", {24'h0, Led}, {24'h0, m_led});
      check("model_dout", {24'h0, D_out}, {24'h0, m_dout});
      check("model_oe", {31'h0, D_oe}, {31'h0, m_oe});
      check("model_stb", {31'h0, wr_strobe}, {31'h0, m_stb});
      check("stb_consecutive", {31'h0, prev_stb & wr_strobe}, 32'h0);
      if (wr_strobe) stb_count++;
      prev_stb = wr_strobe;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic release_bus();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                          input int hold, input int gap);
    A = addr; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
    idle(hold);
    release_bus();
    idle(gap);
  endtask

  int base_cnt;

  initial begin
    reset = 1'b1;
    release_bus();
    A = 8'h00; D_in = 8'h00; sw = 8'h00;
    idle(3);
    check("reset_led", {24'h0, Led}, 32'h0);
    check("reset_oe", {31'h0, D_oe}, 32'h0);
    check("reset_dout", {24'h0, D_out}, 32'h0);
    check("reset_stb", {31'h0, wr_strobe}, 32'h0);
    reset = 1'b0;
    run = 1'b1;
    idle(3);

    // write 0xA5 to LED port, strobe held 20 cycles
    base_cnt = stb_count;
    A = 8'h01; D_in = 8'hA5; nIORQ = 1'b0; nWR = 1'b0;
    idle(S);
    check("wr_before_latency", {24'h0, Led}, 32'h0);
    idle(1);
    check("wr_led_at_latency", {24'h0, Led}, 32'hA5);
    check("wr_strobe_at_latency", {31'h0, wr_strobe}, 32'h1);
    idle(20 - S - 1);
    release_bus();
    idle(S + 2);
    check("wr_one_pulse", stb_count - base_cnt, 32'd1);
    check("wr_state_idle", 32'(dut.state), 32'(IDLE));
    idle(5);

    // write to unmapped port 0x05
    base_cnt = stb_count;
    A = 8'h05; D_in = 8'hFF; nIORQ = 1'b0; nWR = 1'b0;
    idle(S + 1);
    check("unmapped_state_ignore", 32'(dut.state), 32'(IGNORE));
    idle(8);
    release_bus();
    idle(S + 2);
    check("unmapped_led", {24'h0, Led}, 32'hA5);
    check("unmapped_no_pulse", stb_count - base_cnt, 32'd0);
    check("unmapped_state_idle", 32'(dut.state), 32'(IDLE));

    // switch read, switches change mid-cycle
    sw = 8'h3C;
    idle(S + 2);
    A = 8'h02; nIORQ = 1'b0; nRD = 1'b0;
    idle(S);
    check("rd_oe_before_latency", {31'h0, D_oe}, 32'h0);
    idle(1);
    check("rd_oe_at_latency", {31'h0, D_oe}, 32'h1);
    check("rd_dout", {24'h0, D_out}, 32'h3C);
    sw = 8'h00;
    idle(15);
    check("rd_dout_frozen", {24'h0, D_out}, 32'h3C);
    check("rd_oe_held", {31'h0, D_oe}, 32'h1);
    release_bus();
    idle(S);
    check("rd_oe_before_release_latency", {31'h0, D_oe}, 32'h1);
    idle(1);
    check("rd_oe_released", {31'h0, D_oe}, 32'h0);
    idle(5);

    // interrupt acknowledge addressed like the LED port
    base_cnt = stb_count;
    A = 8'h01; D_in = 8'h77; nM1 = 1'b0; nIORQ = 1'b0;
    idle(S + 1);
    check("intack_state_ignore", 32'(dut.state), 32'(IGNORE));
    idle(6);
    release_bus();
    idle(S + 2);
    check("intack_led", {24'h0, Led}, 32'hA5);
    check("intack_oe", {31'h0, D_oe}, 32'h0);
    check("intack_no_pulse", stb_count - base_cnt, 32'd0);

    // back-to-back writes with a 10-cycle idle gap
    base_cnt = stb_count;
    io_write(8'h01, 8'h11, 6, 10);
    check("b2b_first_led", {24'h0, Led}, 32'h11);
    io_write(8'h01, 8'h22, 6, 10);
    check("b2b_pulses", stb_count - base_cnt, 32'd2);
    check("b2b_final_led", {24'h0, Led}, 32'h22);

    // reset asserted while a read is in progress
    sw = 8'h5A;
    idle(S + 2);
    A = 8'h02; nIORQ = 1'b0; nRD = 1'b0;
    idle(S + 3);
    check("pre_reset_oe", {31'h0, D_oe}, 32'h1);
    check("pre_reset_dout", {24'h0, D_out}, 32'h5A);
    #2 reset = 1'b1;
    #1;
    check("async_reset_oe", {31'h0, D_oe}, 32'h0);
    check("async_reset_led", {24'h0, Led}, 32'h0);
    check("async_reset_dout", {24'h0, D_out}, 32'h0);
    release_bus();
    idle(2);
    reset = 1'b0;
    idle(S + 4);
    check("post_reset_state", 32'(dut.state), 32'(IDLE));
    check("post_reset_oe", {31'h0, D_oe}, 32'h0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
